// File: rtl/dec_chsel_if.sv
// Command-decoder pin bundle: envelope input, permit switches,
// channel drive, command strobe/data and status LEDs.
//   master: drives DEC_IN, SW_IN; observes every decoder output
//   slave : the decoder; samples DEC_IN, SW_IN; drives the rest
interface dec_chsel_if #(
    parameter int N_CH       = 2,
    parameter int FRAME_BITS = 4
);
    logic                  DEC_IN;
    logic [N_CH-1:0]       SW_IN;
    logic [N_CH-1:0]       CH_EN;
    logic                  ED_EN;
    logic                  CMD_VALID;
    logic [FRAME_BITS-1:0] CMD_DATA;
    logic                  LED_ACT;
    logic                  LED_ERR;

    modport master (
        output DEC_IN, SW_IN,
        input  CH_EN, ED_EN, CMD_VALID, CMD_DATA, LED_ACT, LED_ERR
    );

    modport slave (
        input  DEC_IN, SW_IN,
        output CH_EN, ED_EN, CMD_VALID, CMD_DATA, LED_ACT, LED_ERR
    );
endinterface

// File: rtl/dec_chsel.sv
// Envelope pulse-width command decoder driving a one-hot channel select.
// Ports: CLKA, RSTN (async active-low), bus (dec_chsel_if.slave).
module dec_chsel #(
    parameter int N_CH       = 2,
    parameter int FRAME_BITS = 4,
    parameter int CNT_W      = 12,
    parameter int GLITCH     = 3,
    parameter int MIN_ON     = 50,
    parameter int THRESH     = 400,
    parameter int MAX_ON     = 1000,
    parameter int GAP_MAX    = 2000
) (
    input logic        CLKA,
    input logic        RSTN,
    dec_chsel_if.slave bus
);
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int BC_W  = $clog2(FRAME_BITS + 1);
    localparam int GF_W  = $clog2(GLITCH + 1);

    localparam logic [CNT_W-1:0] C_MIN  = CNT_W'(MIN_ON);
    localparam logic [CNT_W-1:0] C_THR  = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] C_MAX  = CNT_W'(MAX_ON);
    localparam logic [CNT_W-1:0] C_GAP1 = CNT_W'(GAP_MAX - 1);
    localparam logic [BC_W-1:0]  BC_FULL = BC_W'(FRAME_BITS);
    localparam logic [GF_W-1:0]  GF_LAST = GF_W'(GLITCH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW,
        S_ERR
    } state_t;

    logic                  dec_s1, dec_s2;
    logic [N_CH-1:0]       sw_s1, sw_s2;
    logic                  dec_f, dec_fd;
    logic [GF_W-1:0]       glt_cnt;
    logic [CNT_W-1:0]      cnt;
    state_t                state;
    logic [BC_W-1:0]       bit_cnt;
    logic [FRAME_BITS-1:0] shreg;
    logic [N_CH-1:0]       ch_en;
    logic                  ed_en;
    logic                  cmd_valid;
    logic [FRAME_BITS-1:0] cmd_data;
    logic                  led_err;

    logic                  rise, fall;
    logic                  w_bad, sym;
    logic                  bc_full, gap_hit;
    logic                  en_bit, idx_ok;
    logic [IDX_W-1:0]      idx;
    logic [N_CH-1:0]       sel_oh;

    assign rise    = dec_f & ~dec_fd;
    assign fall    = ~dec_f & dec_fd;
    // a saturated count is always treated as an over-long pulse
    assign w_bad   = (cnt < C_MIN) || (cnt > C_MAX) || (cnt == '1);
    assign sym     = (cnt >= C_THR);
    assign bc_full = (bit_cnt == BC_FULL);
    // true on the edge at which the low count reaches GAP_MAX
    assign gap_hit = (cnt == C_GAP1);
    assign en_bit  = shreg[FRAME_BITS-1];
    assign idx     = shreg[IDX_W-1:0];
    assign idx_ok  = (32'(idx) < N_CH) && sw_s2[idx];
    assign sel_oh  = N_CH'(1) << idx;

    assign bus.CH_EN     = ch_en;
    assign bus.ED_EN     = ed_en;
    assign bus.CMD_VALID = cmd_valid;
    assign bus.CMD_DATA  = cmd_data;
    assign bus.LED_ACT   = |ch_en;
    assign bus.LED_ERR   = led_err;

    // synchronisers, glitch filter and width counter
    always_ff @(posedge CLKA or negedge RSTN) begin
        if (!RSTN) begin
            dec_s1  <= 1'b0;
            dec_s2  <= 1'b0;
            sw_s1   <= '0;
            sw_s2   <= '0;
            dec_f   <= 1'b0;
            dec_fd  <= 1'b0;
            glt_cnt <= '0;
            cnt     <= '0;
        end else begin
            dec_s1 <= bus.DEC_IN;
            dec_s2 <= dec_s1;
            sw_s1  <= bus.SW_IN;
            sw_s2  <= sw_s1;
            dec_fd <= dec_f;
            if (dec_s2 != dec_f) begin
                if (glt_cnt == GF_LAST) begin
                    dec_f   <= dec_s2;
                    glt_cnt <= '0;
                end else begin
                    glt_cnt <= glt_cnt + 1'b1;
                end
            end else begin
                glt_cnt <= '0;
            end
            if (rise || fall) begin
                cnt <= CNT_W'(1);
            end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // frame FSM and command outputs
    always_ff @(posedge CLKA or negedge RSTN) begin
        if (!RSTN) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            ch_en     <= '0;
            ed_en     <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_data  <= '0;
            led_err   <= 1'b0;
        end else begin
            ed_en     <= |sw_s2;
            cmd_valid <= 1'b0;
            // permit drop; a frame for another channel may still override
            if (|(ch_en & ~sw_s2)) begin
                ch_en <= '0;
            end
            if (!ed_en) begin
                state   <= S_IDLE;
                bit_cnt <= '0;
                shreg   <= '0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (rise) begin
                            state   <= S_HIGH;
                            bit_cnt <= '0;
                        end
                    end
                    S_HIGH: begin
                        if (fall) begin
                            if (w_bad) begin
                                state   <= S_ERR;
                                led_err <= 1'b1;
                            end else begin
                                shreg   <= {shreg[FRAME_BITS-2:0], sym};
                                bit_cnt <= bit_cnt + 1'b1;
                                state   <= S_LOW;
                            end
                        end
                    end
                    S_LOW: begin
                        if (rise) begin
                            if (bc_full) begin
                                state   <= S_ERR;
                                led_err <= 1'b1;
                            end else begin
                                state <= S_HIGH;
                            end
                        end else if (gap_hit) begin
                            if (!bc_full) begin
                                state   <= S_ERR;
                                led_err <= 1'b1;
                            end else begin
                                state <= S_IDLE;
                                if (!en_bit || idx_ok) begin
                                    ch_en     <= en_bit ? sel_oh : '0;
                                    cmd_valid <= 1'b1;
                                    cmd_data  <= shreg;
                                    led_err   <= 1'b0;
                                end else begin
                                    led_err <= 1'b1;
                                end
                            end
                        end
                    end
                    S_ERR: begin
                        if (!dec_f && !fall && cnt >= C_GAP1) begin
                            state <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/dec_chsel.md
# dec_chsel

Parametrised envelope-detector command decoder and channel selector for the backscatter tag. It filters the asynchronous `DEC_IN` envelope signal and classifies high-pulse widths into 0/1 symbols. It assembles fixed-length frames and drives a one-hot `CH_EN` bus that selects one of `N_CH` frequency/antenna switch paths. It generalises the fixed two-switch (901/919) control to N channels, adding framing, error detection and a per-channel enable gate from `SW_IN`.

## Interface
- `N_CH`, 2: number of switch channels; `IDX_W = max(1, clog2(N_CH))`.
- `FRAME_BITS`, 4: symbols per frame; must be ≥ `IDX_W+1`.
- `CNT_W`, 12: width of the pulse/gap counter.
- `GLITCH`, 3: cycles a synchronised level must be stable before it is accepted.
- `MIN_ON`, 50: minimum high width, in cycles, for a valid symbol.
- `THRESH`, 400: high width ≥ `THRESH` is a 1; below is a 0.
- `MAX_ON`, 1000: maximum high width for a valid symbol.
- `GAP_MAX`, 2000: low width that terminates a frame. Requires `GAP_MAX` < 2^`CNT_W`-1.

Ports:
- `CLKA` in 1: system clock (20 MHz).
- `RSTN` in 1: asynchronous active-low reset; one clock domain only.
- `DEC_IN` in 1: raw envelope-detector output, asynchronous.
- `SW_IN` in `N_CH`: per-channel permit switches, asynchronous.
- `CH_EN` out `N_CH`: one-hot or all-zero channel drive.
- `ED_EN` out 1: envelope-detector power enable.
- `CMD_VALID` out 1: single-cycle strobe for a completed good frame.
- `CMD_DATA` out `FRAME_BITS`: last good frame, held until the next one.
- `LED_ACT` out 1: equals |`CH_EN`.
- `LED_ERR` out 1: sticky error indicator.

## Operation
- **Input conditioning**
  - `DEC_IN` and `SW_IN` each pass through a 2-flop synchroniser.
  - `DEC_IN` then passes a glitch filter. The filtered level `dec_f` changes only after the synchronised value has differed from it for `GLITCH` consecutive cycles.
- **Counter**
  - One `CNT_W` counter resets to 1 on each `dec_f` edge and increments every cycle.
  - It saturates at all-ones.
- **FSM states:** IDLE, HIGH, LOW, ERR.
  - **IDLE:** on `dec_f` rising, go to HIGH and set `bit_cnt`=0.
  - **HIGH:** on `dec_f` falling, classify the count `w`:
    - `w` < `MIN_ON` or `w` > `MAX_ON` → ERR.
    - Otherwise shift in a symbol, MSB first: 1 if `w` ≥ `THRESH`, else 0. Increment `bit_cnt` and go to LOW.
    - A saturated counter counts as > `MAX_ON`.
  - **LOW:**
    - On `dec_f` rising with `bit_cnt` == `FRAME_BITS` → ERR (too many symbols).
    - On `dec_f` rising otherwise → HIGH.
    - When the count reaches `GAP_MAX` with `bit_cnt` == `FRAME_BITS` → frame done, go to IDLE.
    - When the count reaches `GAP_MAX` with `bit_cnt` ≠ `FRAME_BITS` → ERR.
  - **ERR:** set `LED_ERR`. Stay until `dec_f` has been low for `GAP_MAX` cycles, then go to IDLE.
- **Frame done**
  - Pulse `CMD_VALID` and load `CMD_DATA` with the shift register.
  - Command fields: `en` = bit [`FRAME_BITS`-1]; `idx` = bits [`IDX_W`-1:0].
  - `en`=0 → `CH_EN` becomes all zero.
  - `en`=1, `idx` < `N_CH` and `SW_IN[idx]`=1 → `CH_EN` = one-hot(`idx`).
  - `en`=1 but `idx` ≥ `N_CH`, or `SW_IN[idx]`=0 → treat as an error: set `LED_ERR`, leave `CH_EN` unchanged, do not assert `CMD_VALID`.
- **LED_ERR** clears on the next `CMD_VALID`.
- **Permit drop:** if the synchronised `SW_IN` bit of the active channel goes to 0, `CH_EN` clears on the next cycle. A later frame is required to re-enable it.
- **ED_EN** = OR of the synchronised `SW_IN` bits, registered.
  - While `ED_EN`=0, the FSM is forced to IDLE and the shift register is cleared.
  - `CH_EN` is already 0 in that case, since no channel is permitted.

## Timing
- **Reset values:** `CH_EN`=0, `ED_EN`=0, `CMD_VALID`=0, `CMD_DATA`=0, `LED_ACT`=0, `LED_ERR`=0; FSM in IDLE; counters 0. Reset mid-frame discards all partial state.
- **Filter latency:** 2 + `GLITCH` cycles from a `DEC_IN` edge to a `dec_f` edge. This is equal for both edges, so measured widths equal the true widths.
- **Frame latency:** `CMD_VALID` is asserted `GAP_MAX` cycles after the last `dec_f` falling edge.
- **CH_EN update:** `CH_EN` updates in the same cycle `CMD_VALID` is high; `LED_ACT` follows `CH_EN` combinationally.
- **Simultaneous events:** when a permit drop coincides with frame done for the same channel, the permit drop wins and `CH_EN` = 0.
- **Glitches:** a pulse shorter than `GLITCH` cycles is invisible to the FSM.

## Test plan
All scenarios use default parameters. Long = 600 cycles high, short = 200 cycles high, gap = 30 cycles low.

1. **Select channel 1:** `SW_IN`=2'b11, frame L,S,S,L → `CMD_DATA`=4'b1001, one `CMD_VALID` pulse 2000 cycles after the last fall, `CH_EN`=2'b10, `LED_ACT`=1.
2. **Disable:** after scenario 1, frame S,S,S,S → `CH_EN`=0, `CMD_DATA`=4'b0000.
3. **Bad pulse width:** a 20-cycle pulse inside a frame → `LED_ERR`=1, no `CMD_VALID`, `CH_EN` unchanged. A following good frame L,S,S,S → `CH_EN`=2'b01 and `LED_ERR`=0.
4. **Symbol count errors:**
   - Three-symbol frame → `LED_ERR` after the gap.
   - Five-symbol frame → `LED_ERR` at the 5th rise.
   - Neither case produces `CMD_VALID`.
5. **Permit gating:**
   - `SW_IN`=2'b01 with frame L,S,S,L → `LED_ERR`, `CH_EN`=0.
   - Channel 0 active, then `SW_IN[0]` dropped → `CH_EN`=0 within 3 cycles.
6. **Glitch immunity and reset:**
   - 2-cycle spikes on `DEC_IN` → no state change.
   - `RSTN` low mid-frame → all outputs 0 immediately; a fresh frame then decodes correctly.
